// File: rtl/risc15_pkg.sv
// Shared definitions for the writeback stage: opcode encodings, NOP encoding,
// register-file geometry and the condition-code payload.
package risc15_pkg;

  localparam int unsigned XLEN    = 16;
  localparam int unsigned REG_CNT = 8;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned RC_W    = 32;

  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(7);
  localparam logic [XLEN-1:0]   NOP_IR = 16'hF000;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_ADI  = 4'b0001,
    OP_NAND = 4'b0010,
    OP_LHI  = 4'b0011,
    OP_LW   = 4'b0100,
    OP_SW   = 4'b0101,
    OP_LM   = 4'b0110,
    OP_SM   = 4'b0111,
    OP_JAL  = 4'b1000,
    OP_JLR  = 4'b1001,
    OP_BEQ  = 4'b1100,
    OP_NOP  = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic carry;
    logic zero;
  } ccr_t;

endpackage

// File: rtl/wb_dest_decode.sv
// Destination-register decode for the writeback instruction.
// Ports: ir (writeback instruction) -> dest_c (destination index),
//        we_c (instruction writes the register file).
module wb_dest_decode
  import risc15_pkg::*;
(
  input  logic [XLEN-1:0]   ir,
  output logic [REG_AW-1:0] dest_c,
  output logic              we_c
);

  opcode_e opc_c;
  logic    unused_bits_c;

  assign opc_c         = opcode_e'(ir[15:12]);
  assign unused_bits_c = ^ir[2:0];

  // Field position of the destination depends on the instruction format
  always_comb begin
    dest_c = '0;
    we_c   = 1'b0;
    case (opc_c)
      OP_ADD, OP_NAND: begin
        dest_c = ir[5:3];
        we_c   = 1'b1;
      end
      OP_ADI: begin
        dest_c = ir[8:6];
        we_c   = 1'b1;
      end
      OP_LHI, OP_LW, OP_JAL, OP_JLR: begin
        dest_c = ir[11:9];
        we_c   = 1'b1;
      end
      default: begin
        dest_c = '0;
        we_c   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback-stage register file: 8 x 16-bit registers, condition codes and
// a PC-update pulse when R7 is written.
// Ports: clk, reset (async active-low); IR, RF_value, CCRWrite, carry_in
//        (writeback request); rd_addr_a/b -> rd_data_a/b (combinational reads
//        with write-first bypass); ccr {carry, zero}; pc_wr_en/pc_wr_data
//        (registered one-cycle R7 notification).
// Optional: define WB_RETIRE_COUNT_EN to add the 32-bit retire_count output.
module writeback_regfile
  import risc15_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   IR,
  input  logic [XLEN-1:0]   RF_value,
  input  logic              CCRWrite,
  input  logic              carry_in,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [XLEN-1:0]   rd_data_a,
  output logic [XLEN-1:0]   rd_data_b,
  output logic [1:0]        ccr,
  output logic              pc_wr_en,
`ifdef WB_RETIRE_COUNT_EN
  output logic [XLEN-1:0]   pc_wr_data,
  output logic [RC_W-1:0]   retire_count
`else
  output logic [XLEN-1:0]   pc_wr_data
`endif
);

  logic [XLEN-1:0]   regs [REG_CNT];
  ccr_t              ccr_q;
  logic              live;
  logic [REG_AW-1:0] dest_c;
  logic              dec_we_c;
  logic              wr_en_c;
  logic              is_nop_c;
  logic              ccr_upd_c;

  wb_dest_decode u_dec (
    .ir     (IR),
    .dest_c (dest_c),
    .we_c   (dec_we_c)
  );

  // Low during reset and the first edge after release, so that edge commits nothing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  assign is_nop_c  = (IR == NOP_IR);
  assign wr_en_c   = dec_we_c && live;
  assign ccr_upd_c = live && CCRWrite && !is_nop_c;

  // Register array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REG_CNT); i++) regs[i] <= '0;
    end else if (wr_en_c) begin
      regs[dest_c] <= RF_value;
    end
  end

  // Condition codes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccr_q <= '0;
    end else if (ccr_upd_c) begin
      ccr_q.carry <= carry_in;
      ccr_q.zero  <= (RF_value == '0);
    end
  end

  assign ccr = ccr_q;

  // PC notification: pulse follows the R7 write; data holds between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_wr_en   <= 1'b0;
      pc_wr_data <= '0;
    end else begin
      pc_wr_en <= wr_en_c && (dest_c == PC_IDX);
      if (wr_en_c && (dest_c == PC_IDX)) pc_wr_data <= RF_value;
    end
  end

  // Read ports with write-first bypass
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (wr_en_c && (rd_addr_a == dest_c)) rd_data_a = RF_value;
    if (wr_en_c && (rd_addr_b == dest_c)) rd_data_b = RF_value;
  end

`ifdef WB_RETIRE_COUNT_EN
  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 retire_count <= '0;
    else if (live && !is_nop_c) retire_count <= retire_count + RC_W'(1);
  end
`endif

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port IR  input  16  writeback-stage instruction; 16'hF000 is NOP.
REQ-004 SHALL have port RF_value  input  16  result to write to the destination register.
REQ-005 SHALL have port CCRWrite  input  1  1 = update condition codes this cycle.
REQ-006 SHALL have port carry_in  input  1  carry produced for this instruction.
REQ-007 SHALL have ports rd_addr_a, rd_addr_b  input  3 each  read-port addresses.
REQ-008 SHALL have ports rd_data_a, rd_data_b  output  16 each  read-port data.
REQ-009 SHALL have port ccr  output  2  {carry, zero} flags.
REQ-010 SHALL have port pc_wr_en  output  1  pulses when R7 is written.
REQ-011 SHALL have port pc_wr_data  output  16  value written to R7.

Function
REQ-012 SHALL hold 8 x 16-bit registers R0..R7 plus a 2-bit CCR.
REQ-013 SHALL decode opcode IR[15:12]: 0000/0010 -> dest IR[5:3]; 0001 -> dest IR[8:6]; 0011/0100/1000/1001 -> dest IR[11:9]; all others (incl. 0101, 0110, 0111, 1100, 1111) -> no write.
REQ-014 SHALL write RF_value to the decoded destination on the rising edge of the same cycle IR is presented (one-cycle write latency).
REQ-015 SHALL drive read ports combinationally, with write-first bypass: if a read address equals this cycle's active write destination, return RF_value instead of stored contents.
REQ-016 SHALL, when CCRWrite=1 and IR is not NOP, load ccr.zero = (RF_value == 16'h0000) and ccr.carry = carry_in on the clock edge.
REQ-017 SHALL ignore CCRWrite when IR is NOP (CCR unchanged).
REQ-018 SHALL assert pc_wr_en for exactly one cycle, registered, in the cycle after a write to R7, with pc_wr_data = value written.
REQ-019 SHALL keep pc_wr_data stable at its last value when pc_wr_en=0.
REQ-020 SHALL treat back-to-back writes to the same register as last-writer-wins with no stall.

Reset
REQ-021 SHALL, while reset=0, asynchronously clear R0..R7 to 16'h0000, ccr to 2'b00, pc_wr_en to 0 and pc_wr_data to 16'h0000.
REQ-022 SHALL suppress any write, CCR update or pc_wr_en pulse presented in the cycle reset deasserts.
REQ-023 SHALL discard a pending pc_wr_en pulse if reset asserts between the R7 write and the pulse.

Configuration
REQ-024 SHALL, with macro WB_RETIRE_COUNT_EN defined, add output retire_count (32 bits), reset to 0, incremented by 1 per non-NOP IR on each clock, wrapping 32'hFFFFFFFF -> 0.
REQ-025 SHALL, without WB_RETIRE_COUNT_EN, omit the retire_count port and its counter entirely.

Structure
REQ-026 SHALL place opcode constants, NOP encoding (16'hF000), register count (8) and PC register index (7) in the shared package risc15_pkg.
REQ-027 SHALL implement destination decode in sub-module wb_dest_decode (IR in; dest address and write-enable out).

Verification
REQ-028 SHALL cover: ADD IR=16'h0258 (rc=R3), RF_value=16'h1234, CCRWrite=1, carry_in=1 -> next cycle R3=16'h1234, ccr=2'b10.
REQ-029 SHALL cover: ADI to R5 with RF_value=0, CCRWrite=1, carry_in=0 -> ccr=2'b01; same cycle rd_addr_a=5 returns 16'h0000 via bypass.
REQ-030 SHALL cover: NOP 16'hF000 with CCRWrite=1, RF_value=16'hFFFF -> no register or CCR change.
REQ-031 SHALL cover: JAL to R7 with RF_value=16'h0040 -> next cycle pc_wr_en=1 for one cycle, pc_wr_data=16'h0040.
REQ-032 SHALL cover: SW and BEQ instructions -> no register writes; reset=0 mid-sequence -> all registers and ccr read 0 immediately.
REQ-033 SHALL cover (WB_RETIRE_COUNT_EN): counter preloaded near 32'hFFFFFFFF, two non-NOP retirements -> retire_count=1.
